// File: rtl/sprite_draw_sequencer_pkg.sv
// sprite_draw_sequencer_pkg: shared pixel widths, screen defaults and sequencer state encoding
package sprite_draw_sequencer_pkg;
    localparam int X_W          = 9;
    localparam int Y_W          = 8;
    localparam int COLOUR_W     = 3;
    localparam int DEF_SCREEN_W = 320;
    localparam int DEF_SCREEN_H = 240;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GRANT,
        WAIT_DONE,
        NEXT,
        FRAME_END
    } seq_state_t;
endpackage

// File: rtl/sprite_draw_sequencer_frame_tick_gen.sv
// frame_tick_gen: free-running divider that flags the last cycle of every FRAME_DIV-cycle frame
module frame_tick_gen #(
    parameter int FRAME_DIV = 833333
) (
    input  logic clk,
    input  logic resetn,
    output logic tick
);
    localparam int CW = $clog2(FRAME_DIV);
    localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

    logic [CW-1:0] count;

    assign tick = count == LAST;

    // Count 0..FRAME_DIV-1 and wrap; tick marks the wrap cycle
    always_ff @(posedge clk) begin
        if (!resetn) count <= '0;
        else         count <= tick ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/sprite_draw_sequencer.sv
// sprite_draw_sequencer: per-frame screen clear, then round-robin grant of sprite clients onto the VGA write port
module sprite_draw_sequencer
    import sprite_draw_sequencer_pkg::*;
#(
    parameter int                  N_CLIENTS    = 4,
    parameter int                  FRAME_DIV    = 833333,
    parameter int                  SCREEN_W     = DEF_SCREEN_W,
    parameter int                  SCREEN_H     = DEF_SCREEN_H,
    parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = '0,
    parameter int                  DONE_TIMEOUT = 4096
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [X_W*N_CLIENTS-1:0]        client_x,
    input  logic [Y_W*N_CLIENTS-1:0]        client_y,
    input  logic [COLOUR_W*N_CLIENTS-1:0]   client_colour,
    input  logic [N_CLIENTS-1:0]            client_plot,
    input  logic [N_CLIENTS-1:0]            client_done,
    output logic [N_CLIENTS-1:0]            client_enable,
    output logic [X_W-1:0]                  vga_x,
    output logic [Y_W-1:0]                  vga_y,
    output logic [COLOUR_W-1:0]             vga_colour,
    output logic                            vga_writeEn,
    output logic                            move_tick,
    output logic                            busy,
    output logic                            overrun,
    output logic                            timeout_err
);
    localparam int IDX_W = N_CLIENTS > 1 ? $clog2(N_CLIENTS) : 1;
    localparam int TC_W  = DONE_TIMEOUT > 1 ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [X_W-1:0]   X_LAST   = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(SCREEN_H - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CLIENTS - 1);
    localparam logic [TC_W-1:0]  T_LAST   = TC_W'(DONE_TIMEOUT - 1);

    seq_state_t       state;
    logic             tick;
    logic             tick_pending;
    logic [X_W-1:0]   cx;
    logic [Y_W-1:0]   cy;
    logic [IDX_W-1:0] idx;
    logic [TC_W-1:0]  tcnt;

    frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .tick   (tick)
    );

    assign busy = state != IDLE;

    // Frame sequencer: clear sweep, per-client grant/wait with timeout, registered pixel mux
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            tick_pending  <= 1'b0;
            cx            <= '0;
            cy            <= '0;
            idx           <= '0;
            tcnt          <= '0;
            client_enable <= '0;
            vga_x         <= '0;
            vga_y         <= '0;
            vga_colour    <= '0;
            vga_writeEn   <= 1'b0;
            move_tick     <= 1'b0;
            overrun       <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            vga_writeEn <= 1'b0;
            move_tick   <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick_pending) begin
                        tick_pending <= 1'b0;
                        cx           <= '0;
                        cy           <= '0;
                        state        <= CLEAR;
                    end
                end
                CLEAR: begin
                    vga_x       <= cx;
                    vga_y       <= cy;
                    vga_colour  <= CLEAR_COLOUR;
                    vga_writeEn <= 1'b1;
                    if (cx == X_LAST) begin
                        cx <= '0;
                        if (cy == Y_LAST) begin
                            cy    <= '0;
                            idx   <= '0;
                            state <= GRANT;
                        end else begin
                            cy <= cy + 1'b1;
                        end
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                GRANT: begin
                    client_enable      <= '0;
                    client_enable[idx] <= 1'b1;
                    tcnt               <= '0;
                    state              <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    vga_x       <= client_x[idx*X_W +: X_W];
                    vga_y       <= client_y[idx*Y_W +: Y_W];
                    vga_colour  <= client_colour[idx*COLOUR_W +: COLOUR_W];
                    vga_writeEn <= client_plot[idx];
                    if (client_done[idx] || tcnt == T_LAST) begin
                        client_enable <= '0;
                        state         <= NEXT;
                        if (!client_done[idx]) timeout_err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                NEXT: begin
                    if (idx == IDX_LAST) begin
                        state <= FRAME_END;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= GRANT;
                    end
                end
                FRAME_END: begin
                    move_tick <= 1'b1;
                    idx       <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A wrap always leaves one tick pending; a second wrap while pending is simply absorbed
            if (tick) begin
                tick_pending <= 1'b1;
                if (state != IDLE) overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// tb_sprite_draw_sequencer: frame-schedule reference model plus directed scenarios for the draw sequencer
module tb_sprite_draw_sequencer;
    localparam int N   = 2;
    localparam int DIV = 24;
    localparam int W   = 4;
    localparam int H   = 2;
    localparam int TO  = 8;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [9*N-1:0]   client_x = '0;
    logic [8*N-1:0]   client_y = '0;
    logic [3*N-1:0]   client_colour = '0;
    logic [N-1:0]     client_plot = '0;
    logic [N-1:0]     client_done = '0;
    logic [N-1:0]     client_enable;
    logic [8:0]       vga_x;
    logic [7:0]       vga_y;
    logic [2:0]       vga_colour;
    logic             vga_writeEn;
    logic             move_tick;
    logic             busy;
    logic             overrun;
    logic             timeout_err;

    int n_chk = 0;
    int n_pass = 0;

    // client script: len = cycles of enable before done (0 = never done); noise = idle clients spam plot/done
    bit noise = 1'b0;
    int len [N] = '{3, 3};
    int kk [N];
    bit was_en [N];

    sprite_draw_sequencer #(
        .N_CLIENTS    (N),
        .FRAME_DIV    (DIV),
        .SCREEN_W     (W),
        .SCREEN_H     (H),
        .CLEAR_COLOUR (3'b000),
        .DONE_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .client_x      (client_x),
        .client_y      (client_y),
        .client_colour (client_colour),
        .client_plot   (client_plot),
        .client_done   (client_done),
        .client_enable (client_enable),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_colour    (vga_colour),
        .vga_writeEn   (vga_writeEn),
        .move_tick     (move_tick),
        .busy          (busy),
        .overrun       (overrun),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Client behaviour: granted client plots pixels k=1..len and pulses done together with pixel len
    int px, py, pc;
    logic pl, dn;
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < N; i++) begin
            if (client_enable[i]) kk[i] = was_en[i] ? kk[i] + 1 : 0;
            was_en[i] = client_enable[i];
            if (client_enable[i]) begin
                pl = kk[i] >= 1 && (len[i] == 0 || kk[i] <= len[i]);
                dn = len[i] != 0 && kk[i] == len[i];
                px = 5 + 40 * i + kk[i] - 1;
                py = 7 + 16 * i + kk[i] - 1;
                pc = 5 + i + kk[i] - 1;
            end else begin
                pl = noise;
                dn = noise;
                px = 300 + i;
                py = 200 + i;
                pc = 7;
            end
            client_x[9*i +: 9]      = 9'(px);
            client_y[8*i +: 8]      = 8'(py);
            client_colour[3*i +: 3] = 3'(pc);
            client_plot[i]          = pl;
            client_done[i]          = dn;
        end
    end

    // Reference model: frame schedule as pixel/client progress counters, predicting outputs after the next edge
    int   m_cnt = 0, m_pix = 0, m_cl = 0, m_w = 0;
    bit   m_pend = 0, m_frame = 0, m_gnt = 0, m_last = 0, m_rst = 1, tk;
    logic [N-1:0] e_en = '0;
    logic [8:0]   e_x = '0;
    logic [7:0]   e_y = '0;
    logic [2:0]   e_c = '0;
    logic         e_we = 0, e_mt = 0, e_ov = 0, e_te = 0, e_busy = 0;

    always @(negedge clk) begin
        check("busy", busy, e_busy);
        check("client_enable", client_enable, e_en);
        check("vga_writeEn", vga_writeEn, e_we);
        check("move_tick", move_tick, e_mt);
        check("overrun", overrun, e_ov);
        check("timeout_err", timeout_err, e_te);
        if (e_we || m_rst) begin
            check("vga_x", vga_x, e_x);
            check("vga_y", vga_y, e_y);
            check("vga_colour", vga_colour, e_c);
        end
        if (!resetn) begin
            m_cnt = 0; m_pend = 0; m_frame = 0; m_pix = 0; m_cl = 0; m_gnt = 0; m_last = 0; m_w = 0;
            e_en = '0; e_we = 0; e_mt = 0; e_ov = 0; e_te = 0; e_x = '0; e_y = '0; e_c = '0;
            m_rst = 1;
        end else begin
            m_rst = 0;
            tk = m_cnt == DIV - 1;
            m_cnt = tk ? 0 : m_cnt + 1;
            e_we = 0;
            e_mt = 0;
            if (tk && m_frame) e_ov = 1;
            if (!m_frame) begin
                if (m_pend) begin
                    m_frame = 1;
                    m_pix = 0;
                    m_pend = 0;
                end
            end else if (m_pix < W * H) begin
                e_we = 1;
                e_x = 9'(m_pix % W);
                e_y = 8'(m_pix / W);
                e_c = 3'b000;
                m_pix++;
                if (m_pix == W * H) begin
                    m_cl = 0;
                    m_gnt = 1;
                end
            end else if (m_gnt) begin
                e_en = N'(1 << m_cl);
                m_gnt = 0;
                m_w = 0;
            end else if (e_en != '0) begin
                e_we = client_plot[m_cl];
                e_x = client_x[9*m_cl +: 9];
                e_y = client_y[8*m_cl +: 8];
                e_c = client_colour[3*m_cl +: 3];
                m_w++;
                if (client_done[m_cl]) e_en = '0;
                else if (m_w == TO) begin
                    e_en = '0;
                    e_te = 1;
                end
            end else if (m_cl < N - 1) begin
                m_cl++;
                m_gnt = 1;
            end else if (!m_last) begin
                m_last = 1;
            end else begin
                e_mt = 1;
                m_frame = 0;
                m_last = 0;
            end
            if (tk) m_pend = 1;
        end
        e_busy = m_frame;
    end

    // Hold reset for three edges, release, then pin the reset state
    task automatic do_reset();
        @(posedge clk);
        #2 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_enable", client_enable, 0);
        check("rst_writeEn", vga_writeEn, 0);
        check("rst_move", move_tick, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_x", vga_x, 0);
        check("rst_y", vga_y, 0);
        check("rst_colour", vga_colour, 0);
    endtask

    task automatic run_frame(output int first_w, output int move_at, output int writes,
                             output int rises, output logic [8:0] fx, output logic [7:0] fy);
        logic [N-1:0] prev = '0;
        first_w = -1; move_at = -1; writes = 0; rises = 0; fx = '0; fy = '0;
        for (int c = 1; c <= 300 && move_at < 0; c++) begin
            @(negedge clk);
            if (vga_writeEn) begin
                writes++;
                if (first_w < 0) begin
                    first_w = c;
                    fx = vga_x;
                    fy = vga_y;
                end
            end
            rises += $countones(client_enable & ~prev);
            prev = client_enable;
            if (move_tick) move_at = c;
        end
        if (move_at < 0) begin
            n_chk++;
            $display("FAIL frame_bound: move_tick absent after 300 cycles, required within 300");
        end
    endtask

    task automatic wait_move();
        bit seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            seen = move_tick;
        end
        if (!seen) begin
            n_chk++;
            $display("FAIL wait_move: move_tick absent after 200 cycles, required within 200");
        end
    endtask

    task automatic wait_en0();
        bit seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            seen = client_enable[0];
        end
        if (!seen) begin
            n_chk++;
            $display("FAIL wait_en0: client_enable[0] absent after 100 cycles, required within 100");
        end
    endtask

    int fw, ma, wr, ri;
    logic [8:0] fx;
    logic [7:0] fy;

    initial begin
        do_reset();

        // First frame: tick after DIV cycles, clear 4x2, two ideal clients of 3 pixels each
        run_frame(fw, ma, wr, ri, fx, fy);
        check("first_write_cycle", fw, 26);
        check("first_write_x", fx, 0);
        check("first_write_y", fy, 0);
        check("frame_writes", wr, 14);
        check("frame_grants", ri, 2);
        check("move_cycle", ma, 46);
        check("idle_busy0", busy, 0);
        @(negedge clk) check("idle_busy1", busy, 0);
        @(negedge clk) check("idle_busy2", busy, 0);
        @(negedge clk) check("next_frame_busy", busy, 1);

        // Second frame: idle clients spam plot/done; client0 pixel (5,7,5) and done together with a pixel
        noise = 1'b1;
        wait_en0();
        @(negedge clk) check("idle_plot_ignored", vga_writeEn, 0);
        @(negedge clk);
        check("c0_we", vga_writeEn, 1);
        check("c0_x", vga_x, 5);
        check("c0_y", vga_y, 7);
        check("c0_colour", vga_colour, 3'b101);
        @(negedge clk);
        @(negedge clk);
        check("done_pixel_we", vga_writeEn, 1);
        check("done_pixel_x", vga_x, 7);
        check("done_enable_drop", client_enable, 2'b00);
        @(negedge clk) check("next_enable_low", client_enable, 2'b00);
        @(negedge clk) check("grant_client1", client_enable, 2'b10);
        wait_move();

        // Third frame: client1 never finishes, so it times out and the long frame overruns
        len[1] = 0;
        noise = 1'b0;
        wait_move();
        check("timeout_flag", timeout_err, 1);
        check("overrun_flag", overrun, 1);
        check("end_busy", busy, 0);
        @(negedge clk);
        check("pending_restart", busy, 1);
        check("move_single", move_tick, 0);

        // Reset in the middle of the clear sweep, then a clean frame from (0,0)
        len[1] = 3;
        do_reset();
        run_frame(fw, ma, wr, ri, fx, fy);
        check("re_first_write_cycle", fw, 26);
        check("re_first_write_x", fx, 0);
        check("re_first_write_y", fy, 0);
        check("re_frame_writes", wr, 14);
        check("re_move_cycle", ma, 46);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
